// File: rtl/env_pkg.sv
// Shared definitions for the per-voice envelope stages (attack, decay, sustain, release).
package env_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECAY,
    SUSTAIN
  } env_state_t;

  localparam int DEF_WIDTH   = 20;
  localparam int DEF_SHIFT_W = 5;
  localparam int DEF_RATE_W  = 8;

endpackage

// File: rtl/decay_stage_if.sv
// Sample stream and control bundle between the envelope controller and the decay stage.
interface decay_stage_if
  import env_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int RATE_W  = DEF_RATE_W
);

  logic               tick;
  logic [WIDTH-1:0]   in;
  logic [SHIFT_W-1:0] decay_amount;
  logic [RATE_W-1:0]  step_rate;
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   out;
  logic [SHIFT_W-1:0] shift_amount;
  logic               busy;
  logic               start_sustain;

  modport master (
    output tick, in, decay_amount, step_rate, start, abort,
    input  out, shift_amount, busy, start_sustain
  );

  modport slave (
    input  tick, in, decay_amount, step_rate, start, abort,
    output out, shift_amount, busy, start_sustain
  );

endinterface

// File: rtl/env_rate_div.sv
// Tick prescaler: emits a single-cycle step every step_rate+1 enabled ticks.
module env_rate_div #(
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              clear,
  input  logic              enable,
  input  logic [RATE_W-1:0] step_rate,
  output logic              step
);

  logic [RATE_W-1:0] count;
  logic              wrap;

  // >= rather than == so a step_rate lowered mid-count cannot strand the counter.
  assign wrap = (count >= step_rate);
  assign step = enable && tick && !clear && wrap;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && tick) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/decay_stage.sv
// Envelope decay stage: right-shift attenuation that deepens by one per step until decay_amount.
module decay_stage
  import env_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int RATE_W  = DEF_RATE_W
) (
  input  logic          clk,
  input  logic          reset_n,
  decay_stage_if.slave  bus
);

  env_state_t         state;
  logic [SHIFT_W-1:0] shift;
  logic [WIDTH-1:0]   out_q;
  logic               busy_q;
  logic               sustain_q;
  logic               abort_hit;
  logic               terminate;
  logic               step;

  assign abort_hit = bus.abort && (state != IDLE);
  assign terminate = (state == DECAY) && (shift >= bus.decay_amount);

  env_rate_div #(
    .RATE_W (RATE_W)
  ) u_rate_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (bus.tick),
    .clear     (bus.start),
    .enable    ((state == DECAY) && !abort_hit && !terminate),
    .step_rate (bus.step_rate),
    .step      (step)
  );

  // Branch order encodes precedence: start, then abort, then termination, then stepping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      shift     <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      sustain_q <= 1'b0;
    end else begin
      out_q     <= bus.in >> shift;
      sustain_q <= 1'b0;
      if (bus.start) begin
        state  <= DECAY;
        shift  <= '0;
        busy_q <= 1'b1;
      end else if (abort_hit) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else if (terminate) begin
        state     <= SUSTAIN;
        busy_q    <= 1'b0;
        sustain_q <= 1'b1;
      end else if (step && (shift != '1)) begin
        shift <= shift + 1'b1;
      end
    end
  end

  assign bus.out           = out_q;
  assign bus.shift_amount  = shift;
  assign bus.busy          = busy_q;
  assign bus.start_sustain = sustain_q;

endmodule

// File: tb/tb_decay_stage.sv
// Self-checking bench for decay_stage: cycle scoreboard plus per-scenario directed checks.
module tb_decay_stage;
  import env_pkg::*;

  localparam int WIDTH   = 20;
  localparam int SHIFT_W = 5;
  localparam int RATE_W  = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  decay_stage_if #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .RATE_W(RATE_W)) bus ();

  decay_stage #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .RATE_W(RATE_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [SHIFT_W-1:0] shift;
    logic               busy;
    logic               ss;
    logic [WIDTH-1:0]   out;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails = 0;
  int ss_pulses = 0;
  bit rand_in = 1'b0;

  env_state_t         m_state;
  logic [SHIFT_W-1:0] m_shift;
  logic [RATE_W-1:0]  m_pre;

  // Drive one clock of stimulus, advance the reference model and queue what the DUT must show.
  task automatic drive(input logic s, input logic a, input logic t);
    exp_t e;
    bus.start = s;
    bus.abort = a;
    bus.tick  = t;
    if (rand_in) bus.in = WIDTH'($urandom);
    e.out = reset_n ? (bus.in >> m_shift) : '0;
    e.ss  = 1'b0;
    if (!reset_n) begin
      m_state = IDLE;
      m_shift = '0;
      m_pre   = '0;
    end else if (s) begin
      m_state = DECAY;
      m_shift = '0;
      m_pre   = '0;
    end else if (a && m_state != IDLE) begin
      m_state = IDLE;
    end else if (m_state == DECAY && m_shift >= bus.decay_amount) begin
      m_state = SUSTAIN;
      e.ss    = 1'b1;
    end else if (m_state == DECAY && t) begin
      if (m_pre >= bus.step_rate) begin
        m_pre = '0;
        if (m_shift != {SHIFT_W{1'b1}}) m_shift = SHIFT_W'(m_shift + 1);
      end else begin
        m_pre = RATE_W'(m_pre + 1);
      end
    end
    e.shift = m_shift;
    e.busy  = (m_state == DECAY);
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.tick  = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.shift_amount !== e.shift || bus.busy !== e.busy ||
          bus.start_sustain !== e.ss || bus.out !== e.out) begin
        fails++;
        $display("[TB] FAIL scoreboard t=%0t got shift=%0d busy=%0b ss=%0b out=%h want shift=%0d busy=%0b ss=%0b out=%h",
                 $time, bus.shift_amount, bus.busy, bus.start_sustain, bus.out, e.shift, e.busy, e.ss, e.out);
      end
    end
    if (bus.start_sustain === 1'b1) ss_pulses++;
  end

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 0, 0);
    drive(0, 0, 1);
    checks++; if (bus.shift_amount !== '0) begin fails++; $display("[TB] FAIL reset_shift got %0d want 0", bus.shift_amount); end
    checks++; if (bus.out !== '0) begin fails++; $display("[TB] FAIL reset_out got %h want 0", bus.out); end
    checks++; if (bus.busy !== 1'b0 || bus.start_sustain !== 1'b0) begin fails++; $display("[TB] FAIL reset_flags got busy=%0b ss=%0b want 0 0", bus.busy, bus.start_sustain); end
    reset_n = 1'b1;
    drive(0, 0, 0);
  endtask

  task automatic test_reset_mid_decay();
    int p0;
    bus.in = 20'hFFFFF; bus.decay_amount = 5'd10; bus.step_rate = '0;
    drive(1, 0, 0);
    repeat (3) drive(0, 0, 1);
    checks++; if (bus.shift_amount !== 5'd3 || bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL mid_pre_reset got shift=%0d busy=%0b want 3 1", bus.shift_amount, bus.busy); end
    reset_n = 1'b0;
    drive(0, 0, 1);
    reset_n = 1'b1;
    checks++; if (bus.shift_amount !== '0 || bus.out !== '0 || bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset got shift=%0d out=%h busy=%0b want 0 0 0", bus.shift_amount, bus.out, bus.busy); end
    p0 = ss_pulses;
    repeat (6) drive(0, 0, 1);
    checks++; if (ss_pulses != p0 || bus.busy !== 1'b0 || bus.shift_amount !== '0) begin fails++; $display("[TB] FAIL mid_after got pulses=%0d busy=%0b shift=%0d want %0d 0 0", ss_pulses, bus.busy, bus.shift_amount, p0); end
  endtask

  task automatic test_normal();
    int p0;
    bus.in = 20'hFFFFF; bus.decay_amount = 5'd4; bus.step_rate = '0;
    drive(1, 0, 1);
    checks++; if (bus.shift_amount !== '0 || bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL normal_start got shift=%0d busy=%0b want 0 1", bus.shift_amount, bus.busy); end
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 1);
      checks++; if (bus.shift_amount !== SHIFT_W'(k)) begin fails++; $display("[TB] FAIL normal_step got %0d want %0d", bus.shift_amount, k); end
    end
    p0 = ss_pulses;
    drive(0, 0, 1);
    checks++; if (bus.start_sustain !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL normal_term got ss=%0b busy=%0b want 1 0", bus.start_sustain, bus.busy); end
    checks++; if (bus.out !== 20'h0FFFF) begin fails++; $display("[TB] FAIL normal_out got %h want 0ffff", bus.out); end
    repeat (4) drive(0, 0, 1);
    checks++; if (bus.shift_amount !== 5'd4 || ss_pulses != p0 + 1) begin fails++; $display("[TB] FAIL normal_hold got shift=%0d pulses=%0d want 4 %0d", bus.shift_amount, ss_pulses, p0 + 1); end
  endtask

  task automatic test_prescaler();
    bus.in = 20'h12345; bus.decay_amount = 5'd2; bus.step_rate = 8'd2;
    drive(1, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      drive(0, 0, 1);
      checks++; if (bus.shift_amount !== SHIFT_W'(k / 3)) begin fails++; $display("[TB] FAIL presc_shift tick %0d got %0d want %0d", k, bus.shift_amount, k / 3); end
      for (int j = 0; j < 3; j++) begin
        drive(0, 0, 0);
        checks++; if (bus.start_sustain !== ((k == 6 && j == 0) ? 1'b1 : 1'b0)) begin fails++; $display("[TB] FAIL presc_ss tick %0d idle %0d got %0b", k, j, bus.start_sustain); end
      end
    end
  endtask

  task automatic test_zero_depth();
    bus.in = 20'hABCDE; bus.decay_amount = '0; bus.step_rate = '0;
    drive(1, 0, 0);
    checks++; if (bus.busy !== 1'b1 || bus.start_sustain !== 1'b0) begin fails++; $display("[TB] FAIL zero_first got busy=%0b ss=%0b want 1 0", bus.busy, bus.start_sustain); end
    drive(0, 0, 1);
    checks++; if (bus.start_sustain !== 1'b1 || bus.busy !== 1'b0 || bus.shift_amount !== '0) begin fails++; $display("[TB] FAIL zero_term got ss=%0b busy=%0b shift=%0d want 1 0 0", bus.start_sustain, bus.busy, bus.shift_amount); end
    drive(0, 0, 1);
    checks++; if (bus.start_sustain !== 1'b0 || bus.shift_amount !== '0) begin fails++; $display("[TB] FAIL zero_after got ss=%0b shift=%0d want 0 0", bus.start_sustain, bus.shift_amount); end
  endtask

  task automatic test_overshoot();
    bus.in = 20'hFFFFF; bus.decay_amount = 5'd10; bus.step_rate = '0;
    drive(1, 0, 0);
    repeat (6) drive(0, 0, 1);
    checks++; if (bus.shift_amount !== 5'd6) begin fails++; $display("[TB] FAIL over_pre got %0d want 6", bus.shift_amount); end
    bus.decay_amount = 5'd3;
    drive(0, 0, 1);
    checks++; if (bus.start_sustain !== 1'b1 || bus.shift_amount !== 5'd6 || bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL over_term got ss=%0b shift=%0d busy=%0b want 1 6 0", bus.start_sustain, bus.shift_amount, bus.busy); end
    drive(0, 0, 1);
    checks++; if (bus.start_sustain !== 1'b0 || bus.shift_amount !== 5'd6) begin fails++; $display("[TB] FAIL over_hold got ss=%0b shift=%0d want 0 6", bus.start_sustain, bus.shift_amount); end
  endtask

  task automatic test_retrigger_abort();
    bit done = 1'b0;
    bus.in = 20'h80000; bus.decay_amount = 5'd5; bus.step_rate = '0;
    drive(1, 0, 0);
    for (int i = 0; i < 20 && !done; i++) begin
      drive(0, 0, 1);
      if (bus.start_sustain === 1'b1) done = 1'b1;
    end
    checks++; if (!done) begin fails++; $display("[TB] FAIL retrig_wait got no start_sustain want pulse within 20 cycles"); end
    checks++; if (bus.shift_amount !== 5'd5) begin fails++; $display("[TB] FAIL retrig_sustain got %0d want 5", bus.shift_amount); end
    drive(1, 0, 1);
    checks++; if (bus.shift_amount !== '0 || bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL retrig got shift=%0d busy=%0b want 0 1", bus.shift_amount, bus.busy); end
    repeat (2) drive(0, 0, 1);
    drive(0, 1, 1);
    checks++; if (bus.shift_amount !== 5'd2 || bus.busy !== 1'b0 || bus.start_sustain !== 1'b0) begin fails++; $display("[TB] FAIL abort got shift=%0d busy=%0b ss=%0b want 2 0 0", bus.shift_amount, bus.busy, bus.start_sustain); end
    drive(0, 1, 1);
    repeat (3) drive(0, 0, 1);
    checks++; if (bus.shift_amount !== 5'd2 || bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_idle got shift=%0d busy=%0b want 2 0", bus.shift_amount, bus.busy); end
    drive(1, 1, 0);
    checks++; if (bus.busy !== 1'b1 || bus.shift_amount !== '0) begin fails++; $display("[TB] FAIL start_abort got busy=%0b shift=%0d want 1 0", bus.busy, bus.shift_amount); end
  endtask

  task automatic test_deep();
    rand_in = 1'b1;
    bus.decay_amount = 5'd24; bus.step_rate = '0;
    drive(1, 0, 0);
    repeat (30) drive(0, 0, 1);
    checks++; if (bus.shift_amount !== 5'd24 || bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL deep_shift got shift=%0d busy=%0b want 24 0", bus.shift_amount, bus.busy); end
    checks++; if (bus.out !== '0) begin fails++; $display("[TB] FAIL deep_out got %h want 0", bus.out); end
    rand_in = 1'b0;
  endtask

  initial begin
    bus.in = '0; bus.decay_amount = '0; bus.step_rate = '0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.tick = 1'b0;
    m_state = IDLE; m_shift = '0; m_pre = '0;
    test_reset();
    test_reset_mid_decay();
    test_normal();
    test_prescaler();
    test_zero_depth();
    test_overshoot();
    test_retrigger_abort();
    test_deep();
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/decay_stage.md
Name: decay_stage

Overview:
- Parametrised decay stage of the synth amplitude envelope.
- Attenuates the incoming sample stream by a right-shift that grows by one at each programmable step interval until it reaches the requested decay depth.
- On reaching that depth it signals the sustain stage and holds the shift.
- Sits between the attack stage and the sustain stage in the per-voice envelope chain.
- Replaces the divided-clock step source with a single-clock tick enable. Adds a rate prescaler, retrigger, abort and overshoot-safe termination.

Parameters:
- WIDTH, 20, sample width of in/out.
- SHIFT_W, 5, width of decay_amount and shift_amount.
- RATE_W, 8, width of the rate prescaler (step period = step_rate+1 ticks).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous active-low reset.
- tick  input  1  one-cycle envelope time-base strobe.
- in  input  WIDTH  unsigned sample from the previous stage.
- decay_amount  input  SHIFT_W  target shift (decay depth).
- step_rate  input  RATE_W  ticks per shift step, minus one.
- start  input  1  one-cycle pulse that begins or retriggers decay.
- abort  input  1  one-cycle pulse that stops decay and returns to idle.
- out  output  WIDTH  registered attenuated sample.
- shift_amount  output  SHIFT_W  current shift, registered.
- busy  output  1  high while in DECAY.
- start_sustain  output  1  one-cycle pulse on decay completion.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, shift_amount=0, prescaler=0, out=0, busy=0, start_sustain=0. Reset overrides every other input, including mid-decay.
- States are IDLE, DECAY and SUSTAIN.
  - IDLE: shift is held and out keeps tracking in.
  - start → DECAY with shift=0 and prescaler=0.
- DECAY:
  - On each tick the prescaler increments. When prescaler==step_rate and a tick arrives, prescaler→0 and shift→shift+1.
  - With step_rate=0, shift increments on every tick.
- Termination compare is shift_amount >= decay_amount, not equality. Lowering decay_amount below the current shift ends decay on the next cycle.
- Termination:
  - In DECAY with shift_amount >= decay_amount: state→SUSTAIN, start_sustain=1 for exactly one cycle, busy→0.
  - No further increment happens in the terminating cycle.
- decay_amount=0 at start: DECAY lasts one cycle, then SUSTAIN with start_sustain pulsed and shift=0.
- Shift never wraps. It saturates at all-ones (2^SHIFT_W-1).
- SUSTAIN: shift is held and ticks are ignored.
  - start → DECAY from shift=0 (retrigger).
  - abort → IDLE.
- Priority in the same cycle: reset_n > start > abort > termination > tick step. start and abort together means start wins.
- start while in DECAY restarts from shift=0 and clears the prescaler. start_sustain is not pulsed.
- abort in DECAY → IDLE, shift held, no start_sustain. abort in IDLE has no effect.
- Datapath: out <= in >> shift_amount every cycle, one cycle of latency from in.
  - out uses the registered shift value from the same edge's previous state.
  - Shift ≥ WIDTH yields out=0.
- busy = (state==DECAY), registered with the state.

Decomposition:
- Shared package env_pkg:
  - state enum env_state_t {IDLE, DECAY, SUSTAIN}.
  - Default WIDTH/SHIFT_W/RATE_W constants, reused by the attack, sustain and release stages.
- One sub-module, env_rate_div:
  - Ports: clk, reset_n, tick, clear, enable, step_rate.
  - Emits a one-cycle step pulse every step_rate+1 enabled ticks.
  - Reused by the attack and release stages.

Test Plan:
- Reset mid-decay: shift=3, assert reset_n=0 for one edge → shift_amount=0, out=0, busy=0, state IDLE, start_sustain never pulses.
- Normal decay, step_rate=0, decay_amount=4, tick every cycle, in=20'hFFFFF:
  - shift steps 0,1,2,3,4.
  - Exactly one start_sustain pulse.
  - out settles at 20'h0FFFF one cycle after shift=4.
  - Shift stays at 4 thereafter despite ticks.
- Prescaler: step_rate=2, decay_amount=2, tick every 4 cycles → shift increments on every 3rd tick; start_sustain after the 6th tick.
- decay_amount=0 with start → start_sustain pulse 2 cycles after start; shift stays 0; busy high for one cycle.
- Overshoot: decaying to 10, at shift=6 change decay_amount to 3 → next cycle SUSTAIN with start_sustain pulsed, shift held at 6.
- Retrigger and abort:
  - start at shift=5 in SUSTAIN → shift=0, busy=1.
  - abort at shift=2 → IDLE, shift held at 2, no start_sustain.
  - start and abort in the same cycle → DECAY.
